// File: rtl/fp_capture_if.sv
// Bus between the sample source / host and the fp_capture trigger buffer.
// master drives samples, control and read address; slave returns status and read data.
interface fp_capture_if #(
    parameter int unsigned AW = 4
);
    logic          sample_en;
    logic [7:0]    value;
    logic          arm;
    logic          abort;
    logic [7:0]    trig_level;
    logic          trig_falling;
    logic [AW-1:0] pre_count;
    logic [AW-1:0] rd_addr;
    logic          busy;
    logic          triggered;
    logic          done;
    logic [AW-1:0] trig_index;
    logic [7:0]    rd_data;

    modport master (
        output sample_en, value, arm, abort, trig_level, trig_falling, pre_count, rd_addr,
        input  busy, triggered, done, trig_index, rd_data
    );

    modport slave (
        input  sample_en, value, arm, abort, trig_level, trig_falling, pre_count, rd_addr,
        output busy, triggered, done, trig_index, rd_data
    );
endinterface

// File: rtl/fp_capture.sv
// Triggered capture buffer: records pre_count samples before a threshold crossing and the
// rest of a DEPTH-sample window after it, read back in trigger-relative order.
module fp_capture #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input logic         clk,
    input logic         rst_n,
    fp_capture_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StFill, StArmed, StPost, StDone} state_e;

    state_e        state_q;
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] rem_q;
    logic [AW-1:0] pre_q;
    logic [AW-1:0] trig_index_q;
    logic [7:0]    prev_q;
    logic          prev_vld_q;
    logic          busy_q;
    logic          triggered_q;
    logic          done_q;
    logic [7:0]    rd_data_q;
    logic [7:0]    mem_q [DEPTH];

    logic          sample_take;
    logic          trig_hit;
    logic [AW-1:0] rem_init;
    logic [AW-1:0] rd_phys;

    assign sample_take = bus.sample_en &&
                         (state_q == StFill || state_q == StArmed || state_q == StPost);

    assign trig_hit = prev_vld_q &&
                      (bus.trig_falling ?
                       (prev_q > bus.trig_level && bus.value <= bus.trig_level) :
                       (prev_q < bus.trig_level && bus.value >= bus.trig_level));

    assign rem_init = AW'(DEPTH - 1) - pre_q;
    assign rd_phys  = trig_index_q - pre_q + bus.rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wptr_q       <= '0;
            cnt_q        <= '0;
            rem_q        <= '0;
            pre_q        <= '0;
            trig_index_q <= '0;
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
            busy_q       <= 1'b0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
        end else if (bus.abort) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (sample_take) begin
                wptr_q     <= wptr_q + 1'b1;
                prev_q     <= bus.value;
                prev_vld_q <= 1'b1;
            end
            case (state_q)
                StIdle, StDone: begin
                    if (bus.arm) begin
                        pre_q       <= bus.pre_count;
                        wptr_q      <= '0;
                        cnt_q       <= '0;
                        prev_vld_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        triggered_q <= 1'b0;
                        done_q      <= 1'b0;
                        state_q     <= (bus.pre_count == '0) ? StArmed : StFill;
                    end
                end
                StFill: begin
                    if (bus.sample_en) begin
                        cnt_q <= cnt_q + 1'b1;
                        if ((cnt_q + 1'b1) == pre_q) state_q <= StArmed;
                    end
                end
                StArmed: begin
                    if (bus.sample_en && trig_hit) begin
                        trig_index_q <= wptr_q;
                        rem_q        <= rem_init;
                        triggered_q  <= 1'b1;
                        if (rem_init != '0) begin
                            state_q <= StPost;
                        end else begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StPost: begin
                    if (bus.sample_en) begin
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == AW'(1)) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Sample storage is deliberately not reset; contents are only meaningful in DONE.
    always_ff @(posedge clk) begin
        if (sample_take && !bus.abort) mem_q[wptr_q] <= bus.value;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= mem_q[rd_phys];
    end

    assign bus.busy       = busy_q;
    assign bus.triggered  = triggered_q;
    assign bus.done       = done_q;
    assign bus.trig_index = trig_index_q;
    assign bus.rd_data    = rd_data_q;
endmodule

// File: tb/tb_fp_capture.sv
// Directed bench for fp_capture: the bench plays the role of fp_counter and checks windows
// against hand-computed sample values.
module tb_fp_capture;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    fp_capture_if #(.AW(4)) bus ();

    fp_capture #(.DEPTH(16), .AW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string tag, input int idx, input int exp);
        bus.rd_addr = 4'(idx);
        tick();
        check_eq(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    // Arms a capture then feeds start, start+step, ... with gap-1 idle cycles between samples
    // until done. Returns the last value fed.
    task automatic run_capture(input logic [3:0] pre, input logic [7:0] lvl, input logic fall,
                               input logic [7:0] start, input logic [7:0] step, input int gap,
                               input bit arm_in_post, output logic [7:0] last);
        logic [7:0] v;
        bit         ok;
        bit         rearmed;
        bus.pre_count    = pre;
        bus.trig_level   = lvl;
        bus.trig_falling = fall;
        bus.arm          = 1'b1;
        tick();
        bus.arm = 1'b0;
        check_eq("busy_after_arm", 32'(bus.busy), 32'd1);
        v       = start;
        ok      = 1'b0;
        rearmed = 1'b0;
        last    = '0;
        for (int n = 0; n < 200 && !ok; n++) begin
            bus.value     = v;
            bus.sample_en = 1'b1;
            if (arm_in_post && !rearmed && bus.triggered && bus.busy) begin
                bus.arm = 1'b1;
                rearmed = 1'b1;
            end
            tick();
            bus.sample_en = 1'b0;
            bus.arm       = 1'b0;
            last          = v;
            v             = v + step;
            if (bus.done) ok = 1'b1;
            else for (int g = 1; g < gap; g++) tick();
        end
        check_eq("capture_completes", 32'(ok), 32'd1);
        if (arm_in_post) check_eq("rearm_seen_in_post", 32'(rearmed), 32'd1);
    endtask

    task automatic check_ramp_window(input string tag);
        check_eq({tag, "_trig_index"}, 32'(bus.trig_index), 32'd10);
        check_eq({tag, "_triggered"}, 32'(bus.triggered), 32'd1);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        read_chk({tag, "_l0"}, 0, 18);
        read_chk({tag, "_l1"}, 1, 21);
        read_chk({tag, "_l2"}, 2, 24);
        read_chk({tag, "_l3"}, 3, 27);
        read_chk({tag, "_l4"}, 4, 30);
        read_chk({tag, "_l15"}, 15, 63);
    endtask

    initial begin
        logic [7:0] last;
        n_checks         = 0;
        n_fails          = 0;
        rst_n            = 1'b0;
        bus.sample_en    = 1'b0;
        bus.value        = '0;
        bus.arm          = 1'b0;
        bus.abort        = 1'b0;
        bus.trig_level   = '0;
        bus.trig_falling = 1'b0;
        bus.pre_count    = '0;
        bus.rd_addr      = '0;
        repeat (3) tick();
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_triggered", 32'(bus.triggered), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_trig_index", 32'(bus.trig_index), 32'd0);
        check_eq("rst_rd_data", 32'(bus.rd_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Ramp 0,3,6,... rising through 30 with four pre-trigger samples.
        run_capture(4'd4, 8'd30, 1'b0, 8'd0, 8'd3, 1, 1'b0, last);
        check_eq("ramp_last", 32'(last), 32'd63);
        check_ramp_window("ramp");

        // Falling 100,90,80,... through 85, no pre-trigger history.
        run_capture(4'd0, 8'd85, 1'b1, 8'd100, 8'd246, 1, 1'b0, last);
        check_eq("fall_last", 32'(last), 32'd186);
        check_eq("fall_trig_index", 32'(bus.trig_index), 32'd2);
        read_chk("fall_l0", 0, 80);
        read_chk("fall_l1", 1, 70);
        read_chk("fall_l15", 15, 186);

        // Fifteen pre-trigger samples: done on the trigger sample itself (60).
        run_capture(4'd15, 8'd60, 1'b0, 8'd0, 8'd3, 1, 1'b0, last);
        check_eq("max_last", 32'(last), 32'd60);
        check_eq("max_triggered", 32'(bus.triggered), 32'd1);
        check_eq("max_done", 32'(bus.done), 32'd1);
        check_eq("max_trig_index", 32'(bus.trig_index), 32'd4);
        read_chk("max_l0", 0, 15);
        read_chk("max_l14", 14, 57);
        read_chk("max_l15", 15, 60);

        // Abort while ARMED, together with a sample.
        bus.pre_count  = 4'd4;
        bus.trig_level = 8'd200;
        bus.arm        = 1'b1;
        tick();
        bus.arm = 1'b0;
        for (int n = 0; n < 8; n++) begin
            bus.value     = 8'(3 * n);
            bus.sample_en = 1'b1;
            tick();
        end
        check_eq("armed_busy", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort     = 1'b0;
        bus.sample_en = 1'b0;
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_done", 32'(bus.done), 32'd0);
        check_eq("abort_triggered", 32'(bus.triggered), 32'd0);
        bus.arm   = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.arm   = 1'b0;
        bus.abort = 1'b0;
        check_eq("arm_abort_busy", 32'(bus.busy), 32'd0);
        check_eq("arm_abort_done", 32'(bus.done), 32'd0);
        run_capture(4'd4, 8'd30, 1'b0, 8'd0, 8'd3, 1, 1'b0, last);
        check_eq("post_abort_last", 32'(last), 32'd63);
        check_ramp_window("post_abort");

        // Sparse sampling with a second arm issued in POST.
        run_capture(4'd4, 8'd30, 1'b0, 8'd0, 8'd3, 5, 1'b1, last);
        check_eq("sparse_last", 32'(last), 32'd63);
        check_ramp_window("sparse");

        // Asynchronous reset in POST.
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        for (int n = 0; n < 40 && !bus.triggered; n++) begin
            bus.value     = 8'(3 * n);
            bus.sample_en = 1'b1;
            tick();
        end
        bus.sample_en = 1'b0;
        check_eq("pre_reset_post", 32'({bus.busy, bus.triggered}), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("areset_busy", 32'(bus.busy), 32'd0);
        check_eq("areset_triggered", 32'(bus.triggered), 32'd0);
        check_eq("areset_done", 32'(bus.done), 32'd0);
        check_eq("areset_trig_index", 32'(bus.trig_index), 32'd0);
        check_eq("areset_rd_data", 32'(bus.rd_data), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.value     = 8'd99;
        bus.sample_en = 1'b1;
        tick();
        bus.sample_en = 1'b0;
        tick();
        check_eq("idle_after_reset", 32'({bus.busy, bus.triggered, bus.done}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
